dmem_responder: RTL and testbench

- Data-memory responder on the far side of the MEM stage's load/store port.
- Accepts one load or store request at a time over a valid/ready handshake.
- Models a configurable number of wait states, commits byte-enabled stores, and returns one response pulse per request (load data or store acknowledge).
- Lets the pipeline add stall logic against a realistic multi-cycle memory, in place of a zero-latency RAM.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_responder_if.sv | 29 ++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and
// wait-state counter sizing.
package dmem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Largest supported number of wait states.
    localparam int LATENCY_MAX = 15;

    // Width of the wait-state counter; it must hold LATENCY_MAX - 1.
    localparam int CNT_W = $clog2(LATENCY_MAX + 1);

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the MEM stage (master) and the data-memory
// responder (slave).
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. The request fields are sampled only on that edge.
// req_ready is high only while the responder is idle. Every accepted request
// produces exactly one single-cycle rsp_valid pulse, unless a reset aborts it.
// rsp_rdata is load data, 0 for a store acknowledge, and holds its value
// until the next response.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dmem_array.sv
// Word-organised data memory: 2**ADDR_W 32-bit words, one write enable per
// byte lane, synchronous write and combinational read. The contents start at
// zero and are not touched by reset.
module dmem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0] mem [DEPTH] = '{default: '0};

    // Write only the enabled byte lanes; the other lanes keep their contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read the whole word at the current address.
    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage load/store port. It accepts one
// request at a time, waits LATENCY cycles, then commits the store or reads
// the load word and returns a one-cycle response pulse.
import dmem_pkg::*;

module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus,
    output state_t            dbg_state
);

    // Value loaded into the wait counter on acceptance. With no wait states
    // the counter is never used, so it simply loads zero.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               ready_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_rdata_q;

    logic               cap_we;
    logic [ADDR_W-1:0]  cap_addr;
    logic [3:0]         cap_be;
    logic [31:0]        cap_wdata;

    logic               accept;
    logic               to_resp;
    logic               src_we;
    logic [ADDR_W-1:0]  src_addr;
    logic [3:0]         src_be;
    logic [31:0]        src_wdata;
    logic [31:0]        rd_data;

    // Byte-offset and high address bits alias; they are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};

    // Decide whether this edge enters RESP and which request copy drives the
    // memory. With zero wait states the memory access happens on the
    // accepting edge itself, so the live bus fields are used in IDLE.
    always_comb begin
        accept    = bus.req_valid & ready_q;
        src_we    = cap_we;
        src_addr  = cap_addr;
        src_be    = cap_be;
        src_wdata = cap_wdata;
        if (state == IDLE) begin
            src_we    = bus.req_we;
            src_addr  = bus.req_addr[ADDR_W+1:2];
            src_be    = bus.req_be;
            src_wdata = bus.req_wdata;
        end
        to_resp = 1'b0;
        if (state == IDLE && accept && LATENCY == 0) begin
            to_resp = 1'b1;
        end
        if (state == WAIT && cnt == '0) begin
            to_resp = 1'b1;
        end
    end

    // Reset has priority, so a commit edge that coincides with rst is dropped.
    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (to_resp & src_we & ~rst),
        .addr  (src_addr),
        .be    (src_be),
        .wdata (src_wdata),
        .rdata (rd_data)
    );

    // Request FSM with wait counter, captured request and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            cap_we      <= 1'b0;
            cap_addr    <= '0;
            cap_be      <= '0;
            cap_wdata   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (to_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= src_we ? 32'h0 : rd_data;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_we    <= bus.req_we;
                        cap_addr  <= bus.req_addr[ADDR_W+1:2];
                        cap_be    <= bus.req_be;
                        cap_wdata <= bus.req_wdata;
                        cnt       <= CNT_LOAD;
                        ready_q   <= 1'b0;
                        state     <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance for the functional checks
// and a LATENCY=0 instance for back-to-back throughput.
import dmem_pkg::*;

module tb_dmem_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();
    state_t dbg_a;
    state_t dbg_b;

    dmem_responder #(.ADDR_W(10), .LATENCY(LAT_A)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_a.slave),
        .dbg_state (dbg_a)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(LAT_B)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_b.slave),
        .dbg_state (dbg_b)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- scoreboard queues ----------------
    logic [31:0] exp_q_a[$];
    int          exp_cyc_a[$];
    logic [31:0] exp_q_b[$];
    int          exp_cyc_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor for instance A: every response pops one expectation (data and cycle).
    always @(negedge clk) begin
        if (!rst && bus_a.rsp_valid) begin
            total++;
            if (exp_q_a.size() == 0) begin
                bad++;
                $display("FAIL rsp_a_unexpected: got rdata 0x%08h at cycle %0d, none expected",
                         bus_a.rsp_rdata, cyc);
            end else begin
                logic [31:0] d;
                int c;
                d = exp_q_a.pop_front();
                c = exp_cyc_a.pop_front();
                if (bus_a.rsp_rdata !== d || cyc != c) begin
                    bad++;
                    $display("FAIL rsp_a: got 0x%08h at cycle %0d expected 0x%08h at cycle %0d",
                             bus_a.rsp_rdata, cyc, d, c);
                end
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        if (!rst && bus_b.rsp_valid) begin
            total++;
            if (exp_q_b.size() == 0) begin
                bad++;
                $display("FAIL rsp_b_unexpected: got rdata 0x%08h at cycle %0d, none expected",
                         bus_b.rsp_rdata, cyc);
            end else begin
                logic [31:0] d;
                int c;
                d = exp_q_b.pop_front();
                c = exp_cyc_b.pop_front();
                if (bus_b.rsp_rdata !== d || cyc != c) begin
                    bad++;
                    $display("FAIL rsp_b: got 0x%08h at cycle %0d expected 0x%08h at cycle %0d",
                             bus_b.rsp_rdata, cyc, d, c);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one request on instance A. With wait_done set, also measure how
    // many cycles req_ready stays low after acceptance.
    task automatic send_a(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] exp,
                          input logic expect_rsp, input logic wait_done);
        int n;
        int acc;
        n = 0;
        while (!bus_a.req_ready) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                total++; bad++;
                $display("FAIL ready_a_timeout: req_ready stuck low, expected high");
                return;
            end
        end
        bus_a.req_valid = 1'b1;
        bus_a.req_we    = we;
        bus_a.req_addr  = addr;
        bus_a.req_be    = be;
        bus_a.req_wdata = wdata;
        @(posedge clk);
        #1;
        acc = cyc;
        bus_a.req_valid = 1'b0;
        bus_a.req_wdata = $urandom_range(0, 32'hFFFF);
        if (expect_rsp) begin
            exp_q_a.push_back(exp);
            exp_cyc_a.push_back(acc + LAT_A);
        end
        if (wait_done) begin
            n = 0;
            forever begin
                @(negedge clk);
                if (bus_a.req_ready) break;
                n++;
                if (n > 50) break;
            end
            check("ready_low_cycles", 32'(n), 32'(LAT_A + 1));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int waited;
        int prev_acc;
        logic        b_we   [4];
        logic [31:0] b_addr [4];
        logic [3:0]  b_be   [4];
        logic [31:0] b_wd   [4];
        logic [31:0] b_exp  [4];

        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0;
        bus_a.req_be = '0; bus_a.req_wdata = '0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
        bus_b.req_be = '0; bus_b.req_wdata = '0;

        // Reset state.
        do_reset(2);
        check("reset_ready", 32'(bus_a.req_ready), 32'd1);
        check("reset_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("reset_rdata", bus_a.rsp_rdata, 32'h0);
        check("reset_state", 32'(dbg_a), 32'(IDLE));

        // Load of untouched memory.
        send_a(1'b0, 32'h0, 4'h0, 32'h0, 32'h0000_0000, 1'b1, 1'b1);

        // Store then load.
        send_a(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1);
        send_a(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1);

        // Byte lanes, and an all-disabled store.
        send_a(1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0, 1'b1, 1'b1);
        send_a(1'b1, 32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b1, 1'b1);
        send_a(1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'h11BB_33DD, 1'b1, 1'b1);
        send_a(1'b1, 32'h0000_0020, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
        send_a(1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'h11BB_33DD, 1'b1, 1'b1);

        // Address aliasing.
        send_a(1'b1, 32'h0000_1004, 4'hF, 32'h0000_0055, 32'h0, 1'b1, 1'b1);
        send_a(1'b0, 32'h0000_0004, 4'h0, 32'h0, 32'h0000_0055, 1'b1, 1'b1);
        send_a(1'b0, 32'h0000_0007, 4'h0, 32'h0, 32'h0000_0055, 1'b1, 1'b1);

        // Reset in the first WAIT cycle aborts the store.
        send_a(1'b1, 32'h0000_0040, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
        check("abort_in_wait", 32'(dbg_a), 32'(WAIT));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(bus_a.req_ready), 32'd1);
        check("abort_state", 32'(dbg_a), 32'(IDLE));
        send_a(1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'h0000_0000, 1'b1, 1'b1);

        // LATENCY=0: requests held valid back to back.
        b_we[0] = 1'b1; b_addr[0] = 32'h8; b_be[0] = 4'hF;    b_wd[0] = 32'h1234_5678; b_exp[0] = 32'h0;
        b_we[1] = 1'b0; b_addr[1] = 32'h8; b_be[1] = 4'h0;    b_wd[1] = 32'h0;         b_exp[1] = 32'h1234_5678;
        b_we[2] = 1'b1; b_addr[2] = 32'h8; b_be[2] = 4'b1000; b_wd[2] = 32'hAB00_0000; b_exp[2] = 32'h0;
        b_we[3] = 1'b0; b_addr[3] = 32'h8; b_be[3] = 4'h0;    b_wd[3] = 32'h0;         b_exp[3] = 32'hAB34_5678;
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            waited = 0;
            @(negedge clk);
            while (!bus_b.req_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 20) begin
                total++; bad++;
                $display("FAIL ready_b_timeout: req_ready stuck low, expected high");
                break;
            end
            bus_b.req_valid = 1'b1;
            bus_b.req_we    = b_we[i];
            bus_b.req_addr  = b_addr[i];
            bus_b.req_be    = b_be[i];
            bus_b.req_wdata = b_wd[i];
            exp_q_b.push_back(b_exp[i]);
            exp_cyc_b.push_back(cyc + 1 + LAT_B);
            if (i > 0) check("accept_spacing_b", 32'(cyc + 1 - prev_acc), 32'(LAT_B + 2));
            prev_acc = cyc + 1;
        end
        @(posedge clk);
        #1;
        bus_b.req_valid = 1'b0;

        // Drain outstanding responses.
        waited = 0;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        check("drain_a", 32'(exp_q_a.size()), 32'd0);
        check("drain_b", 32'(exp_q_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
